rr_req_client: RTL and testbench



---
 rtl/rr_pkg.sv | 24 ++
 rtl/rr_req_client_if.sv | 35 +++
 rtl/rr_client_fifo.sv | 74 +++++++
 rtl/rr_req_client.sv | 164 ++++++++++++++++
 tb/tb_rr_req_client.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbiter, its requester clients and benches.
//   NUM_REQ           : number of arbiter request ports
//   gnt_t             : encoded grant code
//   rr_client_state_e : requester-client FSM states
//   is_pow2()         : elaboration helper for parameter checks
package rr_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned GNT_W   = 2;

    typedef logic [GNT_W-1:0] gnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } rr_client_state_e;

    // True for 1, 2, 4, 8, ...
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/rr_req_client_if.sv
// Bundle of the upstream beat, arbiter and granted-beat signals of one requester client.
//   master : the client (consumes upstream beats and grants, drives request and granted beats)
//   slave  : the environment (upstream source, arbiter, downstream sink)
interface rr_req_client_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
);
    import rr_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    in_last;
    logic                    arb_req;
    gnt_t                    arb_gnt;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    gnt_t                    out_id;
    logic                    starve_err;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport master (
        input  in_valid, in_data, in_last, arb_gnt,
        output in_ready, arb_req, out_valid, out_data, out_last, out_id,
               starve_err, fifo_count
    );

    modport slave (
        output in_valid, in_data, in_last, arb_gnt,
        input  in_ready, arb_req, out_valid, out_data, out_last, out_id,
               starve_err, fifo_count
    );

endinterface

// File: rtl/rr_client_fifo.sv
// Synchronous beat FIFO for the requester client. Head is read combinationally
// from the read pointer; no write-to-read bypass, so a beat pushed into an empty
// FIFO is visible one cycle later.
//   arb_clk, arb_rst_n : clock, async active-low reset (clears pointers and count)
//   push, wr_data      : write request and entry (ignored when full)
//   pop                : read request (ignored when empty)
//   head_c             : entry at the read pointer
//   count              : occupancy 0..DEPTH
//   full_c, empty_c    : occupancy flags
module rr_client_fifo
    import rr_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    arb_clk,
    input  logic                    arb_rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_c,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full_c,
    output logic                    empty_c
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
        $error("rr_client_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign head_c  = mem[rd_ptr];

    // Storage: contents are don't-care after reset.
    always_ff @(posedge arb_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rr_req_client.sv
// Requester-side agent for the 4-port round-robin arbiter. Buffers upstream beats,
// requests the arbiter while work is queued, forwards one beat per qualified grant
// cycle, drops the request for one cycle after each packet's last beat and pulses
// starve_err when a non-empty request goes ungranted for MAX_WAIT cycles.
//   arb_clk, arb_rst_n : clock, async active-low reset
//   bus (master)       : in_valid/in_ready/in_data/in_last upstream beats,
//                        arb_req/arb_gnt arbiter handshake,
//                        out_valid/out_data/out_last/out_id granted beat strobe,
//                        starve_err watchdog pulse, fifo_count occupancy
module rr_req_client
    import rr_pkg::*;
#(
    parameter int unsigned CLIENT_ID = 0,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic            arb_clk,
    input  logic            arb_rst_n,
    rr_req_client_if.master bus
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    if (CLIENT_ID >= NUM_REQ) begin : g_bad_id
        $error("rr_req_client: CLIENT_ID out of range");
    end
    if (MAX_WAIT < 1) begin : g_bad_wait
        $error("rr_req_client: MAX_WAIT must be at least 1");
    end

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    rr_client_state_e  state_q;
    rr_client_state_e  state_nxt;
    logic              req_q;
    logic              req_nxt;
    logic              arb_req_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              starve_q;
    logic              starve_nxt;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_nxt;
    logic              out_last_q;
    logic              out_last_nxt;

    entry_t            wr_entry;
    entry_t            head_c;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic              push_c;
    logic              beat_c;

    assign wr_entry = '{last: bus.in_last, data: bus.in_data};
    assign push_c   = bus.in_valid && !fifo_full_c;

    rr_client_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .arb_clk   (arb_clk),
        .arb_rst_n (arb_rst_n),
        .push      (push_c),
        .wr_data   (wr_entry),
        .pop       (beat_c),
        .head_c    (head_c),
        .count     (fifo_count),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    // arb_req_d screens out a default grant code in the first request cycle;
    // req_q screens out the trailing grant after release.
    assign beat_c = (state_q == REQ) && req_q && arb_req_d
                 && (bus.arb_gnt == gnt_t'(CLIENT_ID)) && !fifo_empty_c;

    // Next-state, request, watchdog and granted-beat output logic.
    always_comb begin
        state_nxt    = state_q;
        req_nxt      = 1'b0;
        wait_cnt_nxt = '0;
        starve_nxt   = 1'b0;
        out_data_nxt = out_data_q;
        out_last_nxt = out_last_q;

        if (beat_c) begin
            out_data_nxt = head_c.data;
            out_last_nxt = head_c.last;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty_c) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                end
            end
            REQ: begin
                req_nxt = 1'b1;
                if (beat_c) begin
                    if (head_c.last) begin
                        state_nxt = GAP;
                        req_nxt   = 1'b0;
                    end
                end else if (!fifo_empty_c) begin
                    if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        starve_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    // Starved upstream mid-packet: hold the request, pause the watchdog.
                    wait_cnt_nxt = wait_cnt;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            arb_req_d   <= 1'b0;
            wait_cnt    <= '0;
            starve_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            req_q       <= req_nxt;
            arb_req_d   <= req_q;
            wait_cnt    <= wait_cnt_nxt;
            starve_q    <= starve_nxt;
            out_valid_q <= beat_c;
            out_data_q  <= out_data_nxt;
            out_last_q  <= out_last_nxt;
        end
    end

    assign bus.in_ready   = !fifo_full_c;
    assign bus.arb_req    = req_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_id     = gnt_t'(CLIENT_ID);
    assign bus.starve_err = starve_q;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_rr_req_client.sv
// Directed bench for rr_req_client: one instance with CLIENT_ID=2 for the main
// sequence and one with CLIENT_ID=0 for the idle-grant-code case.
module tb_rr_req_client;
    import rr_pkg::*;

    logic arb_clk;
    logic arb_rst_n;
    int   n_cmp;
    int   n_bad;

    rr_req_client_if #(.DATA_W(8), .DEPTH(4)) if2 ();
    rr_req_client_if #(.DATA_W(8), .DEPTH(4)) if0 ();

    rr_req_client #(
        .CLIENT_ID (2),
        .DATA_W    (8),
        .DEPTH     (4),
        .MAX_WAIT  (4)
    ) dut2 (
        .arb_clk   (arb_clk),
        .arb_rst_n (arb_rst_n),
        .bus       (if2)
    );

    rr_req_client #(
        .CLIENT_ID (0),
        .DATA_W    (8),
        .DEPTH     (4),
        .MAX_WAIT  (4)
    ) dut0 (
        .arb_clk   (arb_clk),
        .arb_rst_n (arb_rst_n),
        .bus       (if0)
    );

    initial begin
        arb_clk = 1'b0;
        forever #5 arb_clk = ~arb_clk;
    end

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge arb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push2(input logic [7:0] d, input logic l);
        if2.in_valid = 1'b1;
        if2.in_data  = d;
        if2.in_last  = l;
        tick();
    endtask

    initial begin
        logic [7:0] seq [3];
        seq[0] = 8'h11;
        seq[1] = 8'h22;
        seq[2] = 8'h33;
        n_cmp = 0;
        n_bad = 0;

        arb_rst_n    = 1'b0;
        if2.in_valid = 1'b0;
        if2.in_data  = 8'h00;
        if2.in_last  = 1'b0;
        if2.arb_gnt  = 2'd2;
        if0.in_valid = 1'b0;
        if0.in_data  = 8'h00;
        if0.in_last  = 1'b0;
        if0.arb_gnt  = 2'd0;
        repeat (2) tick();

        // Reset values
        check("rst_arb_req",    32'(if2.arb_req),    32'd0);
        check("rst_out_valid",  32'(if2.out_valid),  32'd0);
        check("rst_out_data",   32'(if2.out_data),   32'd0);
        check("rst_out_last",   32'(if2.out_last),   32'd0);
        check("rst_starve",     32'(if2.starve_err), 32'd0);
        check("rst_count",      32'(if2.fifo_count), 32'd0);
        check("rst_in_ready",   32'(if2.in_ready),   32'd1);
        check("rst_out_id2",    32'(if2.out_id),     32'd2);
        check("rst_out_id0",    32'(if0.out_id),     32'd0);
        arb_rst_n = 1'b1;
        tick();

        // Single-beat packet, grant held at 2
        push2(8'hA5, 1'b1);
        if2.in_valid = 1'b0;
        check("t1_count_push",  32'(if2.fifo_count), 32'd1);
        check("t1_req_push",    32'(if2.arb_req),    32'd0);
        tick();
        check("t1_req_e0",      32'(if2.arb_req),    32'd1);
        check("t1_ov_e0",       32'(if2.out_valid),  32'd0);
        tick();
        check("t1_req_e1",      32'(if2.arb_req),    32'd1);
        check("t1_ov_e1",       32'(if2.out_valid),  32'd0);
        tick();
        check("t1_ov_e2",       32'(if2.out_valid),  32'd1);
        check("t1_data_e2",     32'(if2.out_data),   32'h0000_00A5);
        check("t1_last_e2",     32'(if2.out_last),   32'd1);
        check("t1_req_gap",     32'(if2.arb_req),    32'd0);
        check("t1_count_e2",    32'(if2.fifo_count), 32'd0);
        tick();
        check("t1_ov_e3",       32'(if2.out_valid),  32'd0);
        check("t1_req_e3",      32'(if2.arb_req),    32'd0);
        tick();
        check("t1_req_idle",    32'(if2.arb_req),    32'd0);

        // Three-beat packet with the grant rotating 0,1,2,3
        if2.arb_gnt = 2'd3;
        push2(8'h11, 1'b0);
        push2(8'h22, 1'b0);
        push2(8'h33, 1'b1);
        if2.in_valid = 1'b0;
        check("t2_count_full3", 32'(if2.fifo_count), 32'd3);
        check("t2_req_before",  32'(if2.arb_req),    32'd1);
        for (int k = 0; k < 12; k++) begin
            if2.arb_gnt = gnt_t'(k % 4);
            tick();
            check("t2_ov",      32'(if2.out_valid),  32'((k % 4) == 2));
            check("t2_req",     32'(if2.arb_req),    32'(k < 10));
            check("t2_starve",  32'(if2.starve_err), 32'd0);
            if ((k % 4) == 2) begin
                check("t2_data", 32'(if2.out_data),  32'(seq[k / 4]));
                check("t2_last", 32'(if2.out_last),  32'(k == 10));
            end
        end
        if2.arb_gnt = 2'd3;
        check("t2_count_end",   32'(if2.fifo_count), 32'd0);

        // CLIENT_ID=0 with grant code stuck at 0: no beat in first request cycle
        if0.in_valid = 1'b1;
        if0.in_data  = 8'h5A;
        if0.in_last  = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        tick();
        check("t3_req_e0",      32'(if0.arb_req),    32'd1);
        check("t3_ov_e0",       32'(if0.out_valid),  32'd0);
        tick();
        check("t3_ov_e1",       32'(if0.out_valid),  32'd0);
        tick();
        check("t3_ov_e2",       32'(if0.out_valid),  32'd1);
        check("t3_data_e2",     32'(if0.out_data),   32'h0000_005A);
        tick();

        // Fill the FIFO with no grant, stall a fifth beat, then grant one cycle
        push2(8'h01, 1'b0);
        push2(8'h02, 1'b0);
        push2(8'h03, 1'b0);
        push2(8'h04, 1'b1);
        check("t4_count_full",  32'(if2.fifo_count), 32'd4);
        check("t4_ready_full",  32'(if2.in_ready),   32'd0);
        push2(8'h05, 1'b1);
        check("t4_count_stall", 32'(if2.fifo_count), 32'd4);
        check("t4_ready_stall", 32'(if2.in_ready),   32'd0);
        if2.arb_gnt = 2'd2;
        tick();
        if2.arb_gnt = 2'd3;
        check("t4_count_pop",   32'(if2.fifo_count), 32'd3);
        check("t4_ready_pop",   32'(if2.in_ready),   32'd1);
        check("t4_ov_pop",      32'(if2.out_valid),  32'd1);
        check("t4_data_pop",    32'(if2.out_data),   32'h0000_0001);
        check("t4_starve_pop",  32'(if2.starve_err), 32'd0);
        tick();
        if2.in_valid = 1'b0;
        check("t4_count_acc",   32'(if2.fifo_count), 32'd4);

        // Starvation: pulse every 4 ungranted cycles, request held
        for (int j = 0; j < 9; j++) begin
            tick();
            check("t5_starve",  32'(if2.starve_err), 32'((j % 4) == 2));
            check("t5_req",     32'(if2.arb_req),    32'd1);
        end
        // Grant mid-count clears the watchdog
        if2.arb_gnt = 2'd2;
        tick();
        if2.arb_gnt = 2'd3;
        check("t5_ov_gnt",      32'(if2.out_valid),  32'd1);
        check("t5_data_gnt",    32'(if2.out_data),   32'h0000_0002);
        check("t5_starve_gnt",  32'(if2.starve_err), 32'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("t5_starve_clr", 32'(if2.starve_err), 32'(j == 3));
        end

        // Asynchronous reset while a granted beat is on the output
        if2.arb_gnt = 2'd2;
        tick();
        check("t6_ov_pre",      32'(if2.out_valid),  32'd1);
        check("t6_data_pre",    32'(if2.out_data),   32'h0000_0003);
        arb_rst_n = 1'b0;
        #2;
        check("t6_req_rst",     32'(if2.arb_req),    32'd0);
        check("t6_ov_rst",      32'(if2.out_valid),  32'd0);
        check("t6_count_rst",   32'(if2.fifo_count), 32'd0);
        check("t6_ready_rst",   32'(if2.in_ready),   32'd1);
        tick();
        arb_rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("t6_ov_after",    32'(if2.out_valid),  32'd0);
            check("t6_req_after",   32'(if2.arb_req),    32'd0);
            check("t6_count_after", 32'(if2.fifo_count), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
